// File: rtl/square_recon_pipe.sv
// Pipelined square reconstruction: square_o = root_i^2 + rem_i using shift-add over STAGES stages.
// The out-of-range remainder check (rem_i > 2*root_i) is done once at the input and rides along.
module square_recon_pipe #(
  parameter int unsigned STAGES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [7:0]  root_i,
  input  logic [8:0]  rem_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [15:0] square_o,
  output logic        err_o
);

  localparam int unsigned BitsPerStage = 8 / STAGES;

  // Stage registers
  logic        valid_q [STAGES];
  logic [7:0]  root_q  [STAGES];
  logic [15:0] acc_q   [STAGES];
  logic        err_q   [STAGES];

  // Next-state values
  logic        valid_d [STAGES];
  logic [7:0]  root_d  [STAGES];
  logic [15:0] acc_d   [STAGES];
  logic        err_d   [STAGES];

  // Operand presented to each stage: stage 0 from the ports, stage k from stage k-1
  logic        in_valid [STAGES];
  logic [7:0]  in_root  [STAGES];
  logic [15:0] in_acc   [STAGES];
  logic        in_err   [STAGES];

  always_comb begin
    in_valid[0] = valid_i;
    in_root[0]  = root_i;
    in_acc[0]   = {7'd0, rem_i};
    in_err[0]   = rem_i > {root_i, 1'b0};
    for (int k = 1; k < STAGES; k++) begin
      in_valid[k] = valid_q[k-1];
      in_root[k]  = root_q[k-1];
      in_acc[k]   = acc_q[k-1];
      in_err[k]   = err_q[k-1];
    end
  end

  // Each stage consumes its slice of root bits LSB-first, adding root<<j for every set bit j.
  always_comb begin
    logic [7:0]  sel;
    logic [15:0] addend;
    for (int k = 0; k < STAGES; k++) begin
      valid_d[k] = in_valid[k];
      root_d[k]  = in_root[k];
      err_d[k]   = in_err[k];
      acc_d[k]   = in_acc[k];
      sel        = in_root[k] >> (k * BitsPerStage);
      addend     = {8'd0, in_root[k]} << (k * BitsPerStage);
      for (int b = 0; b < BitsPerStage; b++) begin
        if (sel[0]) begin
          acc_d[k] = acc_d[k] + addend;
        end
        sel    = sel >> 1;
        addend = addend << 1;
      end
    end
  end

  // Reset wins over stall; stall freezes every stage at once.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= 1'b0;
        root_q[k]  <= 8'd0;
        acc_q[k]   <= 16'd0;
        err_q[k]   <= 1'b0;
      end
    end else if (!stall_i) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_q[k] <= valid_d[k];
        root_q[k]  <= root_d[k];
        acc_q[k]   <= acc_d[k];
        err_q[k]   <= err_d[k];
      end
    end
  end

  always_comb begin
    valid_o  = valid_q[STAGES-1];
    err_o    = valid_q[STAGES-1] & err_q[STAGES-1];
    square_o = (valid_q[STAGES-1] && !err_q[STAGES-1]) ? acc_q[STAGES-1] : 16'd0;
  end

endmodule

// File: tb/tb_square_recon_pipe.sv
// Directed-vector bench for square_recon_pipe: table of single operands, multi-cycle corner
// sequences on the 4-stage instance, and a sweep of all roots across 1/2/4/8-stage instances.
module tb_square_recon_pipe;

  localparam int Lat = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic [7:0]  root_i;
  logic [8:0]  rem_i;
  logic        stall_i;
  logic        vo [4];
  logic [15:0] sq [4];
  logic        eo [4];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  square_recon_pipe #(.STAGES(4)) u_s4 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .root_i(root_i), .rem_i(rem_i),
    .stall_i(stall_i), .valid_o(vo[0]), .square_o(sq[0]), .err_o(eo[0])
  );
  square_recon_pipe #(.STAGES(1)) u_s1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .root_i(root_i), .rem_i(rem_i),
    .stall_i(stall_i), .valid_o(vo[1]), .square_o(sq[1]), .err_o(eo[1])
  );
  square_recon_pipe #(.STAGES(2)) u_s2 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .root_i(root_i), .rem_i(rem_i),
    .stall_i(stall_i), .valid_o(vo[2]), .square_o(sq[2]), .err_o(eo[2])
  );
  square_recon_pipe #(.STAGES(8)) u_s8 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .root_i(root_i), .rem_i(rem_i),
    .stall_i(stall_i), .valid_o(vo[3]), .square_o(sq[3]), .err_o(eo[3])
  );

  typedef struct {
    int root;
    int rem;
    int exp_sq;
    int exp_err;
  } vec_t;

  vec_t vecs [13];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_out(input string name, input int v, input int s, input int e);
    chk({name, ".valid"}, int'(vo[0]), v);
    chk({name, ".square"}, int'(sq[0]), s);
    chk({name, ".err"}, int'(eo[0]), e);
  endtask

  task automatic drive(input int r, input int m);
    valid_i = 1'b1;
    root_i  = 8'(r);
    rem_i   = 9'(m);
  endtask

  int   exp_sq  [256];
  int   exp_err [256];
  int   idx     [4];
  int   r_rem;

  initial begin
    vecs[0]  = '{255, 510, 65535, 0};
    vecs[1]  = '{0,   0,   0,     0};
    vecs[2]  = '{0,   1,   0,     1};
    vecs[3]  = '{16,  33,  0,     1};
    vecs[4]  = '{16,  32,  288,   0};
    vecs[5]  = '{12,  5,   149,   0};
    vecs[6]  = '{200, 0,   40000, 0};
    vecs[7]  = '{1,   2,   3,     0};
    vecs[8]  = '{100, 57,  10057, 0};
    vecs[9]  = '{128, 256, 16640, 0};
    vecs[10] = '{3,   7,   0,     1};
    vecs[11] = '{170, 340, 29240, 0};
    vecs[12] = '{255, 511, 0,     1};

    rst = 1'b1; valid_i = 1'b0; root_i = '0; rem_i = '0; stall_i = 1'b0;
    step();
    step();
    expect_out("in_reset", 0, 0, 0);
    rst = 1'b0;
    step();
    expect_out("first_after_reset", 0, 0, 0);

    // Single operands: output must appear exactly Lat cycles after sampling, idle before.
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].root, vecs[i].rem);
      for (int c = 1; c <= Lat; c++) begin
        step();
        if (c == 1) valid_i = 1'b0;
        if (c < Lat) chk($sformatf("vec%0d.idle", i), int'(vo[0]), 0);
        else expect_out($sformatf("vec%0d", i), 1, vecs[i].exp_sq, vecs[i].exp_err);
      end
      step();
    end

    // Back-to-back operands
    drive(12, 5); step();
    drive(200, 0); step();
    drive(1, 2); step();
    valid_i = 1'b0; step();
    expect_out("b2b0", 1, 149, 0); step();
    expect_out("b2b1", 1, 40000, 0); step();
    expect_out("b2b2", 1, 3, 0); step();
    expect_out("b2b_end", 0, 0, 0);

    // Stall for 3 cycles with two operands in flight; inputs offered during stall are ignored.
    drive(12, 5); step();
    drive(3, 4); step();
    stall_i = 1'b1; drive(100, 1);
    for (int c = 0; c < 3; c++) begin
      step();
      expect_out($sformatf("stall_frozen%0d", c), 0, 0, 0);
    end
    stall_i = 1'b0; valid_i = 1'b0;
    step(); expect_out("stall_pre", 0, 0, 0);
    step(); expect_out("stall_a", 1, 149, 0);
    step(); expect_out("stall_b", 1, 13, 0);
    step(); expect_out("stall_end", 0, 0, 0);

    // Stall while a result is on the output holds it there.
    drive(5, 0); step();
    valid_i = 1'b0; step(); step(); step();
    expect_out("hold0", 1, 25, 0);
    stall_i = 1'b1;
    step(); expect_out("hold1", 1, 25, 0);
    step(); expect_out("hold2", 1, 25, 0);
    stall_i = 1'b0;
    step(); expect_out("hold_end", 0, 0, 0);

    // Reset (with stall high) flushes three in-flight operands; next operand goes right after.
    drive(9, 0); step();
    drive(10, 0); step();
    drive(11, 0); step();
    rst = 1'b1; stall_i = 1'b1; valid_i = 1'b0;
    step();
    expect_out("flush_reset", 0, 0, 0);
    rst = 1'b0; stall_i = 1'b0;
    drive(7, 3);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) valid_i = 1'b0;
      if (c == Lat) expect_out("post_reset_op", 1, 52, 0);
      else expect_out($sformatf("post_reset_idle%0d", c), 0, 0, 0);
    end

    // Sweep all roots through every depth, back-to-back, mixing legal and illegal remainders.
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 4; i++) idx[i] = 0;
    for (int r = 0; r < 256 + 10; r++) begin
      if (r < 256) begin
        r_rem = (r % 3 == 0) ? int'($urandom_range(511, 0)) : int'($urandom_range(2 * r, 0));
        exp_err[r] = (r_rem > 2 * r) ? 1 : 0;
        exp_sq[r]  = (exp_err[r] != 0) ? 0 : r * r + r_rem;
        drive(r, r_rem);
      end else begin
        valid_i = 1'b0;
      end
      step();
      for (int i = 0; i < 4; i++) begin
        if (vo[i]) begin
          if (idx[i] < 256) begin
            chk($sformatf("sweep_i%0d_n%0d.square", i, idx[i]), int'(sq[i]), exp_sq[idx[i]]);
            chk($sformatf("sweep_i%0d_n%0d.err", i, idx[i]), int'(eo[i]), exp_err[idx[i]]);
          end
          idx[i]++;
        end
      end
    end
    for (int i = 0; i < 4; i++) chk($sformatf("sweep_i%0d.count", i), idx[i], 256);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
